// File: rtl/program_sequencer_stack_if.sv
// Control/status bundle between the microcore decoder (master) and the program sequencer (slave).
interface program_sequencer_stack_if #(
  parameter int PM_ADDR_W   = 8,
  parameter int JMP_ADDR_W  = 4,
  parameter int STACK_DEPTH = 4
);
  localparam int SP_W = $clog2(STACK_DEPTH + 1);

  logic                  hold;
  logic                  jmp;
  logic                  jmp_nz;
  logic                  dont_jmp;
  logic                  call;
  logic                  ret;
  logic [JMP_ADDR_W-1:0] jmp_addr;
  logic [PM_ADDR_W-1:0]  pm_addr;
  logic [PM_ADDR_W-1:0]  pc;
  logic [SP_W-1:0]       sp;
  logic                  stack_overflow;
  logic                  stack_underflow;

  modport master (
    output hold, jmp, jmp_nz, dont_jmp, call, ret, jmp_addr,
    input  pm_addr, pc, sp, stack_overflow, stack_underflow
  );

  modport slave (
    input  hold, jmp, jmp_nz, dont_jmp, call, ret, jmp_addr,
    output pm_addr, pc, sp, stack_overflow, stack_underflow
  );
endinterface

// File: rtl/program_sequencer_stack.sv
// Program sequencer: next-fetch address selection, registered pc, LIFO return stack with sticky fault flags.
// pm_addr is combinational from the current pc/stack; pc follows pm_addr one clock later; hold freezes all state.
module program_sequencer_stack #(
  parameter int                   PM_ADDR_W   = 8,
  parameter int                   JMP_ADDR_W  = 4,
  parameter int                   STACK_DEPTH = 4,
  parameter logic [PM_ADDR_W-1:0] RESET_ADDR  = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  program_sequencer_stack_if.slave bus
);
  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int SHIFT = PM_ADDR_W - JMP_ADDR_W;

  logic [PM_ADDR_W-1:0] pc_q;
  logic [PM_ADDR_W-1:0] pc_inc;
  logic [PM_ADDR_W-1:0] target;
  logic [PM_ADDR_W-1:0] pm_next;
  logic [PM_ADDR_W-1:0] stack_top;
  logic [SP_W-1:0]      sp_q;
  logic [SP_W-1:0]      sp_next;
  logic                 push_en;
  logic                 ovf_q;
  logic                 unf_q;
  logic                 ovf_set;
  logic                 unf_set;
  logic                 stack_empty;
  logic                 stack_full;

  // Rounded up to a power of two so the index width matches sp's low bits exactly;
  // entries at or above STACK_DEPTH are never written because sp saturates.
  logic [PM_ADDR_W-1:0] stack_mem [0:(1 << IDX_W)-1];

  assign pc_inc      = pc_q + 1'b1;
  assign target      = PM_ADDR_W'(bus.jmp_addr) << SHIFT;
  assign stack_empty = (sp_q == '0);
  assign stack_full  = (sp_q == SP_W'(STACK_DEPTH));
  assign stack_top   = stack_mem[IDX_W'(sp_q - 1'b1)];

  always_comb begin
    pm_next = pc_inc;
    sp_next = sp_q;
    push_en = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (bus.hold) begin
      pm_next = pc_q;
    end else if (bus.ret) begin
      // ret outranks call; a simultaneous call is discarded completely
      if (!stack_empty) begin
        pm_next = stack_top;
        sp_next = sp_q - 1'b1;
      end else begin
        unf_set = 1'b1;
      end
    end else if (bus.call) begin
      pm_next = target;
      if (!stack_full) begin
        push_en = 1'b1;
        sp_next = sp_q + 1'b1;
      end else begin
        ovf_set = 1'b1;
      end
    end else if (bus.jmp || (bus.jmp_nz && !bus.dont_jmp)) begin
      pm_next = target;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q  <= RESET_ADDR;
      sp_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pm_next;
      sp_q  <= sp_next;
      ovf_q <= ovf_q | ovf_set;
      unf_q <= unf_q | unf_set;
    end
  end

  always_ff @(posedge clk) begin
    if (push_en && !reset) begin
      stack_mem[IDX_W'(sp_q)] <= pc_inc;
    end
  end

  assign bus.pm_addr         = reset ? RESET_ADDR : pm_next;
  assign bus.pc              = pc_q;
  assign bus.sp              = sp_q;
  assign bus.stack_overflow  = ovf_q;
  assign bus.stack_underflow = unf_q;
endmodule

// File: tb/tb_program_sequencer_stack.sv
// Directed bench: default-sized sequencer (8/4/4) plus a wide one (10/4/8), checked against hand-computed values.
module tb_program_sequencer_stack;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  program_sequencer_stack_if #(.PM_ADDR_W(8),  .JMP_ADDR_W(4), .STACK_DEPTH(4)) ia ();
  program_sequencer_stack_if #(.PM_ADDR_W(10), .JMP_ADDR_W(4), .STACK_DEPTH(8)) ib ();

  program_sequencer_stack #(.PM_ADDR_W(8), .JMP_ADDR_W(4), .STACK_DEPTH(4)) dut_a (
    .clk(clk), .reset(reset), .bus(ia)
  );
  program_sequencer_stack #(.PM_ADDR_W(10), .JMP_ADDR_W(4), .STACK_DEPTH(8)) dut_b (
    .clk(clk), .reset(reset), .bus(ib)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    ia.hold = 0; ia.jmp = 0; ia.jmp_nz = 0; ia.dont_jmp = 0;
    ia.call = 0; ia.ret = 0; ia.jmp_addr = '0;
  endtask

  task automatic idle_b();
    ib.hold = 0; ib.jmp = 0; ib.jmp_nz = 0; ib.dont_jmp = 0;
    ib.call = 0; ib.ret = 0; ib.jmp_addr = '0;
  endtask

  logic [7:0] lifo_exp [0:3];

  initial begin
    idle_a();
    idle_b();
    lifo_exp[0] = 8'h31; lifo_exp[1] = 8'h21; lifo_exp[2] = 8'h11; lifo_exp[3] = 8'h07;

    // reset state, pm_addr forced even with a jump requested
    ia.jmp = 1; ia.jmp_addr = 4'h9;
    step();
    check("rst_pm_addr", 32'(ia.pm_addr), 32'h0);
    check("rst_pc", 32'(ia.pc), 32'h0);
    check("rst_sp", 32'(ia.sp), 32'h0);
    check("rst_ovf", 32'(ia.stack_overflow), 32'h0);
    check("rst_unf", 32'(ia.stack_underflow), 32'h0);
    idle_a();
    step();
    reset = 0;
    #1;

    // sequential fetch
    for (int i = 0; i < 5; i++) begin
      check("seq_pc", 32'(ia.pc), 32'(i));
      check("seq_pm_addr", 32'(ia.pm_addr), 32'(i + 1));
      step();
    end
    check("seq_pc5", 32'(ia.pc), 32'h05);
    check("seq_sp", 32'(ia.sp), 32'h0);

    // call / idle / ret
    ia.call = 1; ia.jmp_addr = 4'h3;
    #1 check("call_pm_addr", 32'(ia.pm_addr), 32'h30);
    step();
    idle_a();
    check("call_pc", 32'(ia.pc), 32'h30);
    check("call_sp", 32'(ia.sp), 32'h1);
    step(); step(); step();
    check("sub_pc", 32'(ia.pc), 32'h33);
    ia.ret = 1;
    #1 check("ret_pm_addr", 32'(ia.pm_addr), 32'h06);
    step();
    idle_a();
    check("ret_sp", 32'(ia.sp), 32'h0);
    check("ret_pc", 32'(ia.pc), 32'h06);

    // five nested calls into a depth-4 stack
    for (int i = 1; i <= 5; i++) begin
      ia.call = 1; ia.jmp_addr = 4'(i);
      step();
    end
    idle_a();
    check("nest_pc", 32'(ia.pc), 32'h50);
    check("nest_sp", 32'(ia.sp), 32'h4);
    check("nest_ovf", 32'(ia.stack_overflow), 32'h1);
    check("nest_unf", 32'(ia.stack_underflow), 32'h0);
    for (int i = 0; i < 4; i++) begin
      ia.ret = 1;
      #1 check("lifo_pm_addr", 32'(ia.pm_addr), 32'(lifo_exp[i]));
      step();
    end
    check("lifo_sp", 32'(ia.sp), 32'h0);
    ia.ret = 1;
    #1 check("unf_pm_addr", 32'(ia.pm_addr), 32'h08);
    step();
    idle_a();
    check("unf_flag", 32'(ia.stack_underflow), 32'h1);
    check("unf_sp", 32'(ia.sp), 32'h0);
    check("unf_pc", 32'(ia.pc), 32'h08);

    // conditional jump and hold
    ia.jmp_nz = 1; ia.dont_jmp = 1; ia.jmp_addr = 4'hC;
    #1 check("jnz_blocked", 32'(ia.pm_addr), 32'h09);
    step();
    ia.dont_jmp = 0;
    #1 check("jnz_taken", 32'(ia.pm_addr), 32'hC0);
    step();
    idle_a();
    check("jnz_pc", 32'(ia.pc), 32'hC0);
    ia.hold = 1; ia.jmp = 1; ia.jmp_addr = 4'h2;
    #1 check("hold_pm_addr", 32'(ia.pm_addr), 32'hC0);
    step();
    check("hold_pc1", 32'(ia.pc), 32'hC0);
    ia.ret = 1;
    step();
    check("hold_pc2", 32'(ia.pc), 32'hC0);
    check("hold_sp", 32'(ia.sp), 32'h0);
    idle_a();

    // fresh reset, then wrap at 0xFF
    reset = 1;
    #1 check("rst2_ovf", 32'(ia.stack_overflow), 32'h0);
    check("rst2_unf", 32'(ia.stack_underflow), 32'h0);
    step();
    reset = 0;
    ia.jmp = 1; ia.jmp_addr = 4'hF;
    step();
    idle_a();
    check("jmp_pc", 32'(ia.pc), 32'hF0);
    for (int i = 0; i < 15; i++) step();
    check("wrap_pc", 32'(ia.pc), 32'hFF);
    check("wrap_pm_addr", 32'(ia.pm_addr), 32'h00);
    step();
    check("wrap_pc0", 32'(ia.pc), 32'h00);

    // call then call+ret: pop only
    ia.call = 1; ia.jmp_addr = 4'h5;
    step();
    check("cr_sp1", 32'(ia.sp), 32'h1);
    ia.ret = 1; ia.jmp_addr = 4'h9;
    #1 check("cr_pm_addr", 32'(ia.pm_addr), 32'h01);
    step();
    idle_a();
    check("cr_sp", 32'(ia.sp), 32'h0);
    check("cr_pc", 32'(ia.pc), 32'h01);
    check("cr_ovf", 32'(ia.stack_overflow), 32'h0);

    // async reset between edges
    ia.ret = 1;
    step();
    ia.ret = 0; ia.call = 1; ia.jmp_addr = 4'h7;
    step();
    idle_a();
    check("pre_rst_unf", 32'(ia.stack_underflow), 32'h1);
    check("pre_rst_sp", 32'(ia.sp), 32'h1);
    check("pre_rst_pc", 32'(ia.pc), 32'h70);
    #2 reset = 1;
    #1;
    check("arst_pc", 32'(ia.pc), 32'h0);
    check("arst_sp", 32'(ia.sp), 32'h0);
    check("arst_unf", 32'(ia.stack_underflow), 32'h0);
    check("arst_pm_addr", 32'(ia.pm_addr), 32'h0);
    step();
    reset = 0;
    step();
    check("rel_pc", 32'(ia.pc), 32'h01);

    // wide instance: 10-bit pc, depth 8
    ib.jmp = 1; ib.jmp_addr = 4'hA;
    #1 check("b_jmp_pm_addr", 32'(ib.pm_addr), 32'h280);
    step();
    idle_b();
    check("b_jmp_pc", 32'(ib.pc), 32'h280);
    for (int i = 0; i < 8; i++) begin
      ib.call = 1; ib.jmp_addr = 4'(i);
      step();
      check("b_push_sp", 32'(ib.sp), 32'(i + 1));
    end
    check("b_full_ovf", 32'(ib.stack_overflow), 32'h0);
    ib.jmp_addr = 4'h8;
    step();
    idle_b();
    check("b_ovf", 32'(ib.stack_overflow), 32'h1);
    check("b_ovf_sp", 32'(ib.sp), 32'h8);
    check("b_ovf_pc", 32'(ib.pc), 32'h200);
    ib.ret = 1;
    #1 check("b_pop_pm_addr", 32'(ib.pm_addr), 32'h181);
    step();
    idle_b();
    check("b_pop_sp", 32'(ib.sp), 32'h7);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
